// File: rtl/memory_responder.sv
// Single-port 32-bit word memory answering MAR/MDR requests with WAIT_CYCLES wait states.
// Optional macro MEM_ADDR_CHECK_EN adds out-of-range address detection and the mem_err port.
module memory_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mar_q,
  input  logic [31:0] mdr_q,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mdr_datain,
  output logic        mdr_read,
  output logic        mem_done,
  output logic        busy
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic        mem_err
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t                  state_reg;
  logic [3:0]              wait_cnt_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             wdata_reg;
  logic                    is_write_reg;
  logic                    bad_reg;
  logic                    rd_valid_reg;
  logic [31:0]             rd_word_reg;
  logic [31:0]             mem [DEPTH];

  logic accept;
  logic addr_bad;

  assign accept = mem_read ^ mem_write;

`ifdef MEM_ADDR_CHECK_EN
  logic err_reg;
  assign addr_bad = |(mar_q >> ADDR_WIDTH);
  assign mem_err  = err_reg;
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^mar_q[31:ADDR_WIDTH];
  assign addr_bad          = 1'b0;
`endif

  // Read word lives in a non-reset register (keeps the array a plain RAM); valid flag gives the 0 reset value.
  assign mdr_datain = rd_valid_reg ? rd_word_reg : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      addr_reg     <= '0;
      wdata_reg    <= 32'h0;
      is_write_reg <= 1'b0;
      bad_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
      mdr_read     <= 1'b0;
      mem_done     <= 1'b0;
      busy         <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
      err_reg      <= 1'b0;
`endif
    end else begin
      mem_done <= 1'b0;
      mdr_read <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
      err_reg  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg     <= mar_q[ADDR_WIDTH-1:0];
            wdata_reg    <= mdr_q;
            is_write_reg <= mem_write;
            bad_reg      <= addr_bad;
            busy         <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_reg <= ACCESS;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_INIT;
            end
          end
`ifdef MEM_ADDR_CHECK_EN
          else if (mem_read && mem_write) begin
            err_reg <= 1'b1;
          end
`endif
        end
        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - 4'd1;
          if (wait_cnt_reg == 4'd1) state_reg <= ACCESS;
        end
        ACCESS: begin
          state_reg <= DONE;
          mem_done  <= 1'b1;
          mdr_read  <= ~is_write_reg;
          if (!is_write_reg) rd_valid_reg <= 1'b1;
`ifdef MEM_ADDR_CHECK_EN
          err_reg   <= bad_reg;
`endif
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Array port: commit or read at the closing edge of ACCESS; a reset in flight blocks the commit.
  always_ff @(posedge clk) begin
    if (state_reg == ACCESS && !reset) begin
      if (is_write_reg) begin
        if (!bad_reg) mem[addr_reg] <= wdata_reg;
      end else begin
        rd_word_reg <= bad_reg ? 32'h0 : mem[addr_reg];
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mar1, mdr1, mar0, mdr0;
  logic        rd1, wr1, rd0, wr0;
  logic [31:0] data1, data0;
  logic        mrd1, mrd0, done1, done0, busy1, busy0;
  logic        err1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .mar_q(mar1), .mdr_q(mdr1),
    .mem_read(rd1), .mem_write(wr1), .mdr_datain(data1),
    .mdr_read(mrd1), .mem_done(done1), .busy(busy1)
`ifdef MEM_ADDR_CHECK_EN
    , .mem_err(err1)
`endif
  );

  memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .mar_q(mar0), .mdr_q(mdr0),
    .mem_read(rd0), .mem_write(wr0), .mdr_datain(data0),
    .mdr_read(mrd0), .mem_done(done0), .busy(busy0)
`ifdef MEM_ADDR_CHECK_EN
    , .mem_err()
`endif
  );

`ifndef MEM_ADDR_CHECK_EN
  assign err1 = 1'b0;
`endif

`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic drive(input bit s, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w);
    if (s) begin mar1 = a; mdr1 = d; rd1 = r; wr1 = w; end
    else   begin mar0 = a; mdr0 = d; rd0 = r; wr0 = w; end
  endtask

  function automatic logic o_busy(input bit s); return s ? busy1 : busy0; endfunction
  function automatic logic o_done(input bit s); return s ? done1 : done0; endfunction
  function automatic logic o_mrd(input bit s);  return s ? mrd1 : mrd0;   endfunction
  function automatic logic o_err(input bit s);  return s ? err1 : 1'b0;   endfunction
  function automatic logic [31:0] o_data(input bit s); return s ? data1 : data0; endfunction

  // One request; lat = negedges after the accept edge until mem_done is seen.
  task automatic run_req(input bit s, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit disturb,
                         output logic [31:0] rdata, output int lat, output int busy_n,
                         output int rd_n, output int err_n);
    bit seen = 1'b0;
    lat = 0; busy_n = 0; rd_n = 0; err_n = 0; rdata = 32'h0;
    @(negedge clk);
    drive(s, addr, data, ~wr, wr);
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (o_busy(s)) busy_n++;
      if (o_mrd(s))  rd_n++;
      if (o_err(s))  err_n++;
      if (o_done(s)) begin
        seen  = 1'b1;
        lat   = i;
        rdata = o_data(s);
        drive(s, 32'h0, 32'h0, 1'b0, 1'b0);
      end else if (disturb && i == 1) begin
        drive(s, addr ^ 32'h1, ~data, 1'b1, 1'b1);
      end
    end
    if (!seen) check("done_timeout", 32'h0, 32'h1);
    @(negedge clk);
    if (o_busy(s)) busy_n++;
    if (o_mrd(s))  rd_n++;
    if (o_err(s))  err_n++;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, bn, rn, en, dn;
    reset = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy1}, 32'h0);
    check("rst_done", {31'h0, done1}, 32'h0);
    check("rst_mrd",  {31'h0, mrd1},  32'h0);
    check("rst_data", data1, 32'h0);
    reset = 1'b0;

    // WAIT_CYCLES=1: write then read address 5
    run_req(1'b1, 1'b1, 32'd5, 32'h4A920000, 1'b0, rd, lat, bn, rn, en);
    check("w5_lat", lat, 3);
    check("w5_busy", bn, 3);
    check("w5_mrd", rn, 0);
    check("w5_data_kept", rd, 32'h0);
    run_req(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, rd, lat, bn, rn, en);
    check("r5_lat", lat, 3);
    check("r5_mrd", rn, 1);
    check("r5_data", rd, 32'h4A920000);
    check("r5_hold", data1, 32'h4A920000);

    // WAIT_CYCLES=0
    run_req(1'b0, 1'b1, 32'd3, 32'h00000011, 1'b0, rd, lat, bn, rn, en);
    check("z_w_lat", lat, 2);
    check("z_w_busy", bn, 2);
    run_req(1'b0, 1'b0, 32'd3, 32'h0, 1'b0, rd, lat, bn, rn, en);
    check("z_r_lat", lat, 2);
    check("z_r_busy", bn, 2);
    check("z_r_mrd", rn, 1);
    check("z_r_data", rd, 32'h00000011);

    // Upper address bits: alias without the check, rejected with it
    run_req(1'b1, 1'b1, 32'd0, 32'h00001234, 1'b0, rd, lat, bn, rn, en);
    run_req(1'b1, 1'b1, 32'h00000200, 32'h0000A5A5, 1'b0, rd, lat, bn, rn, en);
    check("hi_w_lat", lat, 3);
    check("hi_w_err", en, CHK ? 1 : 0);
    run_req(1'b1, 1'b0, 32'd0, 32'h0, 1'b0, rd, lat, bn, rn, en);
    check("a0_data", rd, CHK ? 32'h00001234 : 32'h0000A5A5);
    check("a0_err", en, 0);
    run_req(1'b1, 1'b0, 32'h00000200, 32'h0, 1'b0, rd, lat, bn, rn, en);
    check("hi_r_data", rd, CHK ? 32'h0 : 32'h0000A5A5);
    check("hi_r_err", en, CHK ? 1 : 0);

    // Illegal request: both strobes seen at exactly one IDLE edge
    @(negedge clk);
    drive(1'b1, 32'd5, 32'hDEADBEEF, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    bn = 0; dn = 0; en = (err1 === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      if (busy1) bn++;
      if (done1) dn++;
      @(negedge clk);
      if (err1) en++;
    end
    check("ill_done", dn, 0);
    check("ill_busy", bn, 0);
    check("ill_err", en, CHK ? 1 : 0);
    run_req(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, rd, lat, bn, rn, en);
    check("ill_a5", rd, 32'h4A920000);

    // Strobe and address changes during WAIT are ignored
    run_req(1'b1, 1'b1, 32'd4, 32'h00000044, 1'b0, rd, lat, bn, rn, en);
    run_req(1'b1, 1'b0, 32'd5, 32'h0, 1'b1, rd, lat, bn, rn, en);
    check("dist_lat", lat, 3);
    check("dist_data", rd, 32'h4A920000);
    run_req(1'b1, 1'b0, 32'd4, 32'h0, 1'b0, rd, lat, bn, rn, en);
    check("dist_a4", rd, 32'h00000044);

    // Reset during WAIT aborts a write
    run_req(1'b1, 1'b1, 32'd7, 32'd54, 1'b0, rd, lat, bn, rn, en);
    @(negedge clk);
    drive(1'b1, 32'd7, 32'd91, 1'b0, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, busy1}, 32'h0);
    check("mid_rst_done", {31'h0, done1}, 32'h0);
    check("mid_rst_data", data1, 32'h0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_req(1'b1, 1'b0, 32'd7, 32'h0, 1'b0, rd, lat, bn, rn, en);
    check("mid_rst_a7", rd, 32'd54);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Single-port word memory that answers the datapath's MAR/MDR memory requests. It is the responder end of the MDR memory path. It latches the address from MAR and write data from MDR, inserts a configurable number of wait states, and then performs the access. For reads, it returns the word on `mdr_datain` with a one-cycle `mdr_read` pulse so the MDR can load it. It sits between the datapath (MAR/MDR registers, control unit) and the rest of the system; it replaces bench-driven `mdr_datain`.

## Interface

Parameters:
- `ADDR_WIDTH`, default 9: word-address bits; depth = 2^ADDR_WIDTH words of 32 bits.
- `WAIT_CYCLES`, default 1: wait states inserted before the access; legal range 0..15.

Ports:
- `clk`  input  1  — one clock; all state changes on the rising edge.
- `reset`  input  1  — asynchronous, active-high.
- `mar_q`  input  32  — address from MAR; bits [ADDR_WIDTH-1:0] select the word.
- `mdr_q`  input  32  — write data from MDR.
- `mem_read`  input  1  — read request strobe, held by the initiator until `mem_done`.
- `mem_write`  input  1  — write request strobe, held by the initiator until `mem_done`.
- `mdr_datain`  output  32  — read data to the MDR input mux.
- `mdr_read`  output  1  — MDR input select/load pulse; high only in the DONE cycle of a read.
- `mem_done`  output  1  — one-cycle completion pulse, for reads and writes.
- `busy`  output  1  — high in every state except IDLE.
- `mem_err`  output  1  — address error pulse; present only with `MEM_ADDR_CHECK_EN`.

## Operation

States and transitions:
- IDLE: request sampled here only.
  - `mem_read` XOR `mem_write` high: latch address, data, and direction.
  - Then go to WAIT, or directly to ACCESS if `WAIT_CYCLES`=0.
- WAIT: a 4-bit counter is loaded with `WAIT_CYCLES` and decrements each edge. It moves to ACCESS on the edge where the counter is 1.
- ACCESS: one cycle. At its closing edge:
  - writes commit to the array;
  - reads register `mem[addr]` into `mdr_datain`;
  - state goes to DONE.
- DONE: `mem_done`=1; `mdr_read`=1 if the access was a read. Unconditionally returns to IDLE.

Request rules:
- `mem_read` and `mem_write` both high in IDLE: illegal. No access, no `mem_done`, state stays IDLE.
- Strobes in any state other than IDLE are ignored; there is no queueing.
- Address, data, and direction are latched at acceptance. Later changes to `mar_q`, `mdr_q`, or the strobes do not affect the access in flight.
- The initiator must deassert its strobe by the first edge after the DONE cycle. A strobe still high at the next IDLE edge starts a new access.

Output behaviour:
- `mdr_datain` holds the last read word until the next read completes. Writes never change it.
- Address bits [31:ADDR_WIDTH] are ignored; addresses alias modulo the depth.

Reset:
- Reset value of every output is 0; state goes to IDLE and the wait counter to 0.
- Array contents are not reset.
- Reset asserted before the ACCESS edge aborts the request: no write commit, no `mem_done`.

## Timing

- Request accepted at edge N. The access occurs at edge N+WAIT_CYCLES+1.
- `mem_done` (and `mdr_read` for reads) is high for exactly the cycle after that edge, with `mdr_datain` valid in the same cycle.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles (accept, waits, access, done, idle).
- Read-after-write to the same address returns the new data.

## Configuration

- `MEM_ADDR_CHECK_EN` defined:
  - At acceptance, any nonzero `mar_q[31:ADDR_WIDTH]` flags the request as bad.
  - A bad request still goes through WAIT/ACCESS/DONE, but the write is suppressed and a read returns 32'h00000000.
  - `mem_err`=1 in the DONE cycle alongside `mem_done`.
  - An illegal `mem_read`&`mem_write` in IDLE produces a one-cycle `mem_err` with no `mem_done`.
- `MEM_ADDR_CHECK_EN` undefined: the `mem_err` port and its check logic are absent; upper address bits alias.

## Test plan

- Reset: assert `reset` mid-cycle → all outputs 0 asynchronously, `busy`=0.
- Write/read, `WAIT_CYCLES`=1: write 32'h4A920000 to address 5, then read address 5 → `mem_done` in the cycle after edge N+2; `mdr_datain`=32'h4A920000 with `mdr_read`=1 for one cycle.
- `WAIT_CYCLES`=0: read accepted at edge N → `mem_done` in the cycle after edge N+1; `busy` high for 2 cycles.
- Illegal and ignored requests: `mem_read`=`mem_write`=1 in IDLE → no `mem_done`, array unchanged. A new strobe during WAIT → ignored.
- Reset mid-operation: address 7 holds 32'd54; start a write of 32'd91 and assert `reset` during WAIT; read address 7 afterwards → 32'd54.
- With `MEM_ADDR_CHECK_EN`, `ADDR_WIDTH`=9:
  - write to `mar_q`=32'h00000200 → `mem_err`=1 with `mem_done`, address 0 unchanged;
  - read it back → 32'h0.
- Without `MEM_ADDR_CHECK_EN`: the same write updates address 0.
